inst_fetch_stage: RTL and testbench
===================================

# inst_fetch_stage

Instruction-fetch (IF) stage of the five-stage MIPS pipeline.
- Owns the PC and drives the word address of the combinational instruction ROM, which returns the instruction in the same cycle.
- Registers {PC, instruction} into the IF/ID pipeline register.
- Handles ID back-pressure, branch/jump redirects with one architectural delay slot, and exception flushes.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_addr  output  5  word index to instruction ROM; always equals pc[6:2].
- rom_inst  input  32  instruction returned by ROM for rom_addr; combinational, same cycle.
- id_allow_in  input  1  ID can accept a new IF/ID entry this cycle.
- jbr_taken  input  1  branch/jump in ID resolved taken.
- jbr_target  input  32  redirect target for jbr_taken.
- exc_flush  input  1  exception/eret flush from WB.
- exc_target  input  32  redirect target for exc_flush.
- if_pc  output  32  current fetch PC.
- if_id_valid  output  1  IF/ID entry is valid.
- if_id_pc  output  32  PC of the IF/ID instruction.
- if_id_inst  output  32  instruction held in IF/ID.
- fetch_cnt  output  32  count of instructions delivered to IF/ID.

## Operation
State:
- pc[31:0].
- IF/ID register {valid, pc, inst}.
- pending_valid with pending_target[31:0].
- fetch_cnt.

Address rules:
- pc[1:0] is always 2'b00; the low two bits of any loaded target are forced to 0.
- rom_addr = pc[6:2]. PCs beyond the populated ROM read 0 (nop); no error is raised.

Per-cycle priority (highest first):
1. reset:
   - pc <= RESET_PC.
   - if_id_valid/pc/inst <= 0.
   - pending_valid <= 0, pending_target <= 0.
   - fetch_cnt <= 0.
2. exc_flush:
   - pc <= exc_target & ~3.
   - if_id_valid <= 0; if_id_pc and if_id_inst hold.
   - pending_valid <= 0.
   - fetch_cnt unchanged.
   - Overrides id_allow_in and jbr_taken.
3. id_allow_in = 0 (stall):
   - pc and IF/ID hold.
   - If jbr_taken = 1: pending_valid <= 1 and pending_target <= jbr_target & ~3. The last write wins.
4. id_allow_in = 1 (advance):
   - IF/ID <= {1, pc, rom_inst}; this is the accepted fetch.
   - fetch_cnt <= fetch_cnt + 1, wrapping modulo 2^32.
   - Next PC, in priority order:
     - jbr_target & ~3 if jbr_taken.
     - else pending_target if pending_valid.
     - else pc + 4.
   - pending_valid <= 0.

Delay slot:
- The instruction in IF when a branch in ID resolves is the delay slot. It is always delivered to IF/ID; it is never squashed by jbr_taken.

pc + 4 wraps modulo 2^32 with no flag.

## Timing
- ROM path is combinational: rom_inst is sampled in the same cycle that pc is presented.
- Fetch-to-IF/ID latency is 1 cycle.
- Throughput is 1 instruction per cycle while id_allow_in = 1.
- Reset:
  - The cycle after reset deasserts, pc = RESET_PC and if_id_valid = 0.
  - The first valid IF/ID entry appears one edge later.
- Redirect: the target is fetched in the cycle after the delay slot is accepted into IF/ID.
- Flush: if_id_valid is 0 the cycle after exc_flush, and pc = exc_target in that same cycle.
- A branch during a stall is held in pending_* for any stall length and applied on the first accepting edge.
- exc_flush during a stall discards the pending redirect.
- exc_flush and reset asserted mid-stall take effect on the next edge regardless of id_allow_in.

## Test plan
- Reset then free-run with id_allow_in = 1:
  - if_id_pc = 0, 4, 8 on successive cycles.
  - if_id_inst = 32'h24010001, 32'h00011100, 32'h00411825.
  - fetch_cnt = 3 after three fetches.
- Stall: drop id_allow_in for 3 cycles while pc = 8.
  - pc, if_id_pc (4) and if_id_inst hold.
  - fetch_cnt is unchanged.
  - On release, if_id_pc = 8.
- Branch, unstalled: jbr_taken = 1, jbr_target = 32'h0000_0002 while pc = 32'h14.
  - Next if_id_pc = 32'h14 (delay slot, inst 32'h14620002).
  - pc = 0; target bits [1:0] are cleared.
- Branch during stall: jbr_taken = 1, target = 32'h10, id_allow_in = 0 for 2 cycles, then release with jbr_taken = 0.
  - Delay slot enters IF/ID on release.
  - Next fetch is at 32'h10 (inst 32'hAC040000).
- exc_flush with target 32'h20 while stalled with pending_valid = 1:
  - if_id_valid = 0 and pc = 32'h20 next cycle; pending is cleared.
  - The next accepted inst is 32'h08000000.
- PC past ROM: jump to 32'h7C.
  - if_id_inst = 0 and if_id_valid = 1.
  - pc becomes 32'h80, and rom_addr wraps to 0.

Source files
------------

// File: rtl/inst_fetch_stage.sv
// inst_fetch_stage
//
// Instruction-fetch stage of a five-stage MIPS pipeline. Owns the fetch PC,
// drives the word index of a combinational instruction ROM and registers
// {pc, instruction} into the IF/ID pipeline register.
//
// Behaviour summary:
//   - Branch/jump redirects have one architectural delay slot. The instruction
//     in IF when ID resolves a taken branch is always delivered.
//   - A branch resolved while ID stalls is parked in pending_* until the first
//     accepting edge.
//   - An exception flush from WB overrides everything except reset. It drops
//     the IF/ID entry and discards any parked redirect.
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   synchronous active-high reset
//   rom_addr     out  5   ROM word index, always pc[6:2]
//   rom_inst     in   32  ROM data for rom_addr, same cycle
//   id_allow_in  in   1   ID accepts a new IF/ID entry this cycle
//   jbr_taken    in   1   branch/jump in ID resolved taken
//   jbr_target   in   32  redirect target for jbr_taken
//   exc_flush    in   1   exception/eret flush from WB
//   exc_target   in   32  redirect target for exc_flush
//   if_pc        out  32  current fetch PC
//   if_id_valid  out  1   IF/ID entry valid
//   if_id_pc     out  32  PC of the IF/ID instruction
//   if_id_inst   out  32  instruction held in IF/ID
//   fetch_cnt    out  32  instructions delivered to IF/ID (wraps)

module inst_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [4:0]  rom_addr,
   input  logic [31:0] rom_inst,
   input  logic        id_allow_in,
   input  logic        jbr_taken,
   input  logic [31:0] jbr_target,
   input  logic        exc_flush,
   input  logic [31:0] exc_target,
   output logic [31:0] if_pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_inst,
   output logic [31:0] fetch_cnt
);

   // Word alignment mask applied to every loaded target.
   localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

   logic [31:0] pc_q, pc_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] if_id_pc_q, if_id_pc_d;
   logic [31:0] if_id_inst_q, if_id_inst_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_target_q, pend_target_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   logic [31:0] jbr_target_aligned;
   logic [31:0] exc_target_aligned;
   logic [31:0] pc_seq;

   assign jbr_target_aligned = jbr_target & AlignMask;
   assign exc_target_aligned = exc_target & AlignMask;
   assign pc_seq             = pc_q + 32'd4;

   // Next-state logic: flush > stall > advance. Reset is applied in the
   // register process so it wins over all of these.
   always_comb begin
      pc_d          = pc_q;
      if_id_valid_d = if_id_valid_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_inst_d  = if_id_inst_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      fetch_cnt_d   = fetch_cnt_q;

      if (exc_flush) begin
         // IF/ID pc/inst are left as-is; only the valid bit is dropped.
         pc_d          = exc_target_aligned;
         if_id_valid_d = 1'b0;
         pend_valid_d  = 1'b0;
      end else if (!id_allow_in) begin
         // Park a redirect resolved during the stall; a later one replaces it.
         if (jbr_taken) begin
            pend_valid_d  = 1'b1;
            pend_target_d = jbr_target_aligned;
         end
      end else begin
         // The current fetch is accepted, including any delay slot.
         if_id_valid_d = 1'b1;
         if_id_pc_d    = pc_q;
         if_id_inst_d  = rom_inst;
         fetch_cnt_d   = fetch_cnt_q + 32'd1;
         pend_valid_d  = 1'b0;
         if (jbr_taken) begin
            pc_d = jbr_target_aligned;
         end else if (pend_valid_q) begin
            pc_d = pend_target_q;
         end else begin
            pc_d = pc_seq;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC & AlignMask;
         if_id_valid_q <= 1'b0;
         if_id_pc_q    <= 32'h0;
         if_id_inst_q  <= 32'h0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= 32'h0;
         fetch_cnt_q   <= 32'h0;
      end else begin
         pc_q          <= pc_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_inst_q  <= if_id_inst_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         fetch_cnt_q   <= fetch_cnt_d;
      end
   end

   // The 5-bit index wraps beyond the 32-word ROM window by construction.
   assign rom_addr    = pc_q[6:2];
   assign if_pc       = pc_q;
   assign if_id_valid = if_id_valid_q;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_inst  = if_id_inst_q;
   assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed bench for inst_fetch_stage with a small combinational ROM model.
module tb_inst_fetch_stage;

   logic        clk;
   logic        reset;
   logic [4:0]  rom_addr;
   logic [31:0] rom_inst;
   logic        id_allow_in;
   logic        jbr_taken;
   logic [31:0] jbr_target;
   logic        exc_flush;
   logic [31:0] exc_target;
   logic [31:0] if_pc;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;
   logic [31:0] fetch_cnt;

   int passed;
   int total;

   logic [31:0] rom [32];

   inst_fetch_stage #(
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rom_addr    (rom_addr),
      .rom_inst    (rom_inst),
      .id_allow_in (id_allow_in),
      .jbr_taken   (jbr_taken),
      .jbr_target  (jbr_target),
      .exc_flush   (exc_flush),
      .exc_target  (exc_target),
      .if_pc       (if_pc),
      .if_id_valid (if_id_valid),
      .if_id_pc    (if_id_pc),
      .if_id_inst  (if_id_inst),
      .fetch_cnt   (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rom_inst = rom[rom_addr];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0000 | i;
      rom[0]  = 32'h2401_0001;
      rom[1]  = 32'h0001_1100;
      rom[2]  = 32'h0041_1825;
      rom[4]  = 32'hAC04_0000;
      rom[5]  = 32'h1462_0002;
      rom[8]  = 32'h0800_0000;
      rom[31] = 32'h0000_0000;  // unpopulated word reads as nop

      reset = 1'b1; id_allow_in = 1'b0; jbr_taken = 1'b0; jbr_target = 32'h0;
      exc_flush = 1'b0; exc_target = 32'h0;
      step();
      check("rst_pc", if_pc, 32'h0);
      check("rst_valid", {31'b0, if_id_valid}, 32'h0);
      check("rst_cnt", fetch_cnt, 32'h0);
      check("rst_ifid_pc", if_id_pc, 32'h0);
      check("rst_rom_addr", {27'b0, rom_addr}, 32'h0);

      // Free run
      reset = 1'b0; id_allow_in = 1'b1;
      step();
      check("run0_valid", {31'b0, if_id_valid}, 32'h1);
      check("run0_pc", if_id_pc, 32'h0);
      check("run0_inst", if_id_inst, 32'h2401_0001);
      check("run0_fpc", if_pc, 32'h4);
      step();
      check("run1_pc", if_id_pc, 32'h4);
      check("run1_inst", if_id_inst, 32'h0001_1100);
      check("run1_fpc", if_pc, 32'h8);
      check("run1_cnt", fetch_cnt, 32'd2);

      // Stall three cycles with pc = 8
      id_allow_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_fpc", if_pc, 32'h8);
         check("stall_ifid_pc", if_id_pc, 32'h4);
         check("stall_inst", if_id_inst, 32'h0001_1100);
         check("stall_cnt", fetch_cnt, 32'd2);
      end
      id_allow_in = 1'b1;
      step();
      check("rel_pc", if_id_pc, 32'h8);
      check("rel_inst", if_id_inst, 32'h0041_1825);
      check("rel_cnt", fetch_cnt, 32'd3);
      step();
      check("run3_inst", if_id_inst, 32'h1000_0003);
      step();
      check("run4_inst", if_id_inst, 32'hAC04_0000);
      check("run4_fpc", if_pc, 32'h14);

      // Unstalled branch to misaligned target 2
      jbr_taken = 1'b1; jbr_target = 32'h0000_0002;
      step();
      check("br_ds_pc", if_id_pc, 32'h14);
      check("br_ds_inst", if_id_inst, 32'h1462_0002);
      check("br_fpc", if_pc, 32'h0);
      check("br_cnt", fetch_cnt, 32'd6);

      // Branch during stall; second target replaces the first
      id_allow_in = 1'b0; jbr_taken = 1'b1; jbr_target = 32'h30;
      step();
      jbr_target = 32'h10;
      step();
      check("sbr_fpc", if_pc, 32'h0);
      check("sbr_ifid_pc", if_id_pc, 32'h14);
      id_allow_in = 1'b1; jbr_taken = 1'b0; jbr_target = 32'h0;
      step();
      check("sbr_ds_pc", if_id_pc, 32'h0);
      check("sbr_ds_inst", if_id_inst, 32'h2401_0001);
      check("sbr_fpc", if_pc, 32'h10);
      step();
      check("sbr_tgt_pc", if_id_pc, 32'h10);
      check("sbr_tgt_inst", if_id_inst, 32'hAC04_0000);
      check("sbr_cnt", fetch_cnt, 32'd8);

      // Flush during stall with a pending redirect
      id_allow_in = 1'b0; jbr_taken = 1'b1; jbr_target = 32'h4;
      step();
      jbr_taken = 1'b0; exc_flush = 1'b1; exc_target = 32'h23;
      step();
      check("fl_valid", {31'b0, if_id_valid}, 32'h0);
      check("fl_fpc", if_pc, 32'h20);
      check("fl_ifid_pc", if_id_pc, 32'h10);
      check("fl_cnt", fetch_cnt, 32'd8);
      exc_flush = 1'b0; id_allow_in = 1'b1;
      step();
      check("fl_next_inst", if_id_inst, 32'h0800_0000);
      check("fl_next_pc", if_id_pc, 32'h20);
      check("fl_pend_clr", if_pc, 32'h24);

      // Jump past the populated ROM
      jbr_taken = 1'b1; jbr_target = 32'h7C;
      step();
      check("far_fpc", if_pc, 32'h7C);
      jbr_taken = 1'b0;
      step();
      check("far_inst", if_id_inst, 32'h0);
      check("far_valid", {31'b0, if_id_valid}, 32'h1);
      check("far_fpc2", if_pc, 32'h80);
      check("far_rom_addr", {27'b0, rom_addr}, 32'h0);
      check("far_cnt", fetch_cnt, 32'd11);

      // Reset mid-stall
      id_allow_in = 1'b0; reset = 1'b1;
      step();
      check("rst2_pc", if_pc, 32'h0);
      check("rst2_valid", {31'b0, if_id_valid}, 32'h0);
      check("rst2_cnt", fetch_cnt, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
